// File: rtl/axi_pkg.sv
// Shared AXI exclusive-access types and helpers, used by the read/write
// subordinates and the exclusive monitor.
package axi_pkg;

    localparam int AXI_AW_MAX = 64;

    typedef enum logic {
        EX_IDLE  = 1'b0,
        EX_ARMED = 1'b1
    } ex_state_e;

    // Built at the widest supported address; users keep the low AW bits.
    typedef struct packed {
        logic [AXI_AW_MAX-1:0] addr;
        logic [AXI_AW_MAX-1:0] mask;
    } ex_ctx_t;

    // (1 << size) * (len + 1) peaks at 128 * 256, so 16 bits never overflow.
    function automatic logic [15:0] ex_byte_count(input logic [2:0] size,
                                                  input logic [7:0] len);
        return (16'd1 << size) * (16'(len) + 16'd1);
    endfunction

    function automatic logic ex_legal(input logic [15:0] bc,
                                      input logic [7:0]  len,
                                      input logic [6:0]  addr_lo);
        logic pow2_ok;
        pow2_ok = (bc != 16'd0) && (bc <= 16'd128) &&
                  ((bc & (bc - 16'd1)) == 16'd0);
        return pow2_ok && (len < 8'd16) &&
               ((16'(addr_lo) & (bc - 16'd1)) == 16'd0);
    endfunction

    function automatic ex_ctx_t ex_ctx_make(input logic [AXI_AW_MAX-1:0] addr,
                                            input logic [15:0]           bc);
        ex_ctx_t c;
        c.mask = ~(AXI_AW_MAX'(bc - 16'd1));
        c.addr = addr & c.mask;
        return c;
    endfunction

endpackage

// File: rtl/axi_ex_ctx.sv
// Single-ID exclusive reservation: IDLE/ARMED FSM, {addr, mask} context
// register and optional expiry counter.
module axi_ex_ctx
    import axi_pkg::*;
#(
    parameter int AW    = 32,
    parameter int TMO_W = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] set_mask,
    input  logic          clr,
    output logic          active,
    output logic [AW-1:0] ctx_addr,
    output logic [AW-1:0] ctx_mask,
    output logic          tmo
);

    localparam bit TMO_EN = (TMO_W > 0);
    localparam int CW     = (TMO_W > 0) ? TMO_W : 1;

    ex_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] mask_q, mask_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EX_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Priority: new set > clear > expiry. Expiry fires on the edge where
    // the counter would reach all-ones, so tmo lands 2^TMO_W-1 cycles after arming.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        cnt_inc = cnt_q + CW'(1);
        if (set_en) begin
            state_d = EX_ARMED;
            addr_d  = set_addr;
            mask_d  = set_mask;
            cnt_d   = '0;
        end else if (state_q == EX_ARMED) begin
            if (clr) begin
                state_d = EX_IDLE;
                cnt_d   = '0;
            end else if (TMO_EN) begin
                if (cnt_inc == '1) begin
                    state_d = EX_IDLE;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    assign active   = (state_q == EX_ARMED);
    assign ctx_addr = addr_q;
    assign ctx_mask = mask_q;
    assign tmo      = tmo_q;

endmodule

// File: rtl/axi_ex_mon.sv
// AXI exclusive-access monitor: one reservation per ID, armed by accepted
// exclusive reads and cleared by the write side or by expiry.
module axi_ex_mon
    import axi_pkg::*;
#(
    parameter int  AW     = 32,
    parameter int  IW     = 1,
    parameter int  TMO_W  = 0,
    localparam int ID_NUM = 1 << IW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_valid,
    input  logic [IW-1:0]          set_id,
    input  logic [AW-1:0]          set_addr,
    input  logic [2:0]             set_size,
    input  logic [7:0]             set_len,
    input  logic [ID_NUM-1:0]      ex_clr,
    output logic [ID_NUM-1:0]      ex_active,
    output logic [ID_NUM*2*AW-1:0] ex_ctx,
    output logic                   set_err,
    output logic [ID_NUM-1:0]      tmo
);

    logic [15:0]   set_bc;
    logic          set_legal;
    ex_ctx_t       set_full;
    logic [AW-1:0] set_ctx_addr;
    logic [AW-1:0] set_ctx_mask;
    logic          ctx_unused;

    always_comb begin
        set_bc       = ex_byte_count(set_size, set_len);
        set_legal    = set_valid && ex_legal(set_bc, set_len, set_addr[6:0]);
        set_full     = ex_ctx_make(AXI_AW_MAX'(set_addr), set_bc);
        set_ctx_addr = set_full.addr[AW-1:0];
        set_ctx_mask = set_full.mask[AW-1:0];
    end

    // Bits above AW are always zero-extension / all-ones of the mask.
    assign ctx_unused = ^{set_full.addr, set_full.mask};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_err <= 1'b0;
        end else begin
            set_err <= set_valid && !set_legal;
        end
    end

    for (genvar i = 0; i < ID_NUM; i++) begin : g_id
        axi_ex_ctx #(
            .AW    (AW),
            .TMO_W (TMO_W)
        ) u_ctx (
            .clk      (clk),
            .rst_n    (rst_n),
            .set_en   (set_legal && (set_id == IW'(i))),
            .set_addr (set_ctx_addr),
            .set_mask (set_ctx_mask),
            .clr      (ex_clr[i]),
            .active   (ex_active[i]),
            .ctx_addr (ex_ctx[i*2*AW+AW +: AW]),
            .ctx_mask (ex_ctx[i*2*AW +: AW]),
            .tmo      (tmo[i])
        );
    end

endmodule

// File: tb/tb_axi_ex_mon.sv
// Self-checking bench for axi_ex_mon (AW=32, IW=1, TMO_W=4): directed cases
// followed by random sets/clears against a cycle-level reservation model.
module tb_axi_ex_mon;

    localparam int AW    = 32;
    localparam int IW    = 1;
    localparam int TMO_W = 4;
    localparam int NID   = 2;
    localparam int LIFE  = (1 << TMO_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              set_valid;
    logic [IW-1:0]     set_id;
    logic [AW-1:0]     set_addr;
    logic [2:0]        set_size;
    logic [7:0]        set_len;
    logic [NID-1:0]    ex_clr;
    logic [NID-1:0]    ex_active;
    logic [NID*64-1:0] ex_ctx;
    logic              set_err;
    logic [NID-1:0]    tmo;

    int tests  = 0;
    int failed = 0;

    bit          m_active [NID];
    logic [31:0] m_addr   [NID];
    logic [31:0] m_mask   [NID];
    int          m_age    [NID];
    bit          m_tmo    [NID];
    bit          m_err;

    always #5 clk = ~clk;

    axi_ex_mon #(
        .AW    (AW),
        .IW    (IW),
        .TMO_W (TMO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (set_valid),
        .set_id    (set_id),
        .set_addr  (set_addr),
        .set_size  (set_size),
        .set_len   (set_len),
        .ex_clr    (ex_clr),
        .ex_active (ex_active),
        .ex_ctx    (ex_ctx),
        .set_err   (set_err),
        .tmo       (tmo)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NID; i++) begin
            m_active[i] = 1'b0;
            m_addr[i]   = '0;
            m_mask[i]   = '0;
            m_age[i]    = 0;
            m_tmo[i]    = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Reservation rules stated directly: byte count, alignment, lifetime in cycles.
    task automatic model_edge(input bit v, input int id, input logic [31:0] a,
                              input int sz, input int ln, input logic [NID-1:0] clr);
        int unsigned bc;
        bit          legal;
        bc    = (1 << sz) * (ln + 1);
        legal = v && (bc inside {1, 2, 4, 8, 16, 32, 64, 128}) && (ln < 16) && ((a % bc) == 0);
        m_err = v && !legal;
        for (int i = 0; i < NID; i++) begin
            m_tmo[i] = 1'b0;
            if (legal && id == i) begin
                m_active[i] = 1'b1;
                m_mask[i]   = ~(bc - 1);
                m_addr[i]   = a & ~(bc - 1);
                m_age[i]    = 0;
            end else if (m_active[i]) begin
                if (clr[i]) begin
                    m_active[i] = 1'b0;
                end else begin
                    m_age[i]++;
                    if (m_age[i] == LIFE) begin
                        m_active[i] = 1'b0;
                        m_tmo[i]    = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".active"}, 128'(ex_active), 128'({m_active[1], m_active[0]}));
        chk({tag, ".ctx"}, 128'(ex_ctx), 128'({m_addr[1], m_mask[1], m_addr[0], m_mask[0]}));
        chk({tag, ".err"}, 128'(set_err), 128'(m_err));
        chk({tag, ".tmo"}, 128'(tmo), 128'({m_tmo[1], m_tmo[0]}));
    endtask

    task automatic step(input string tag, input bit v, input int id, input logic [31:0] a,
                        input int sz, input int ln, input logic [NID-1:0] clr);
        @(negedge clk);
        set_valid = v;
        set_id    = IW'(id);
        set_addr  = a;
        set_size  = 3'(sz);
        set_len   = 8'(ln);
        ex_clr    = clr;
        @(posedge clk);
        model_edge(v, id, a, sz, ln, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        int          sz, ln, id;
        logic [31:0] a;
        logic [1:0]  clr;
        bit          v;

        rst_n     = 1'b0;
        set_valid = 1'b0;
        set_id    = '0;
        set_addr  = '0;
        set_size  = '0;
        set_len   = '0;
        ex_clr    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("r022", 1'b1, 0, 32'h40, 2, 1, 2'b00);
        chk("r022_act", 128'(ex_active), 128'(2'b01));
        chk("r022_ctx0", 128'(ex_ctx[63:0]), 128'({32'h40, 32'hFFFF_FFF8}));

        step("r023", 1'b1, 1, 32'h44, 3, 0, 2'b00);
        chk("r023_err", 128'(set_err), 128'(1'b1));
        chk("r023_act", 128'(ex_active), 128'(2'b01));
        step("r023_idle", 1'b0, 0, 32'h0, 0, 0, 2'b00);
        chk("r023_err_drop", 128'(set_err), 128'(1'b0));

        step("r024_arm1", 1'b1, 1, 32'h100, 0, 3, 2'b00);
        chk("r024_both", 128'(ex_active), 128'(2'b11));
        step("r024_clr", 1'b0, 0, 32'h0, 0, 0, 2'b01);
        chk("r024_act", 128'(ex_active), 128'(2'b10));
        chk("r024_ctx0", 128'(ex_ctx[63:0]), 128'({32'h40, 32'hFFFF_FFF8}));
        step("r015_clr_idle", 1'b0, 0, 32'h0, 0, 0, 2'b01);

        step("r025", 1'b1, 0, 32'h80, 0, 0, 2'b01);
        chk("r025_act0", 128'(ex_active[0]), 128'(1'b1));
        chk("r025_ctx0", 128'(ex_ctx[63:0]), 128'({32'h80, 32'hFFFF_FFFF}));

        step("r026_arm", 1'b1, 0, 32'h0, 0, 0, 2'b00);
        for (int k = 1; k <= LIFE; k++) begin
            step("r026_wait", 1'b0, 0, 32'h0, 0, 0, 2'b00);
            chk("r026_tmo0", 128'(tmo[0]), 128'(k == LIFE));
        end
        chk("r026_expired", 128'(ex_active[0]), 128'(1'b0));
        step("r026_after", 1'b0, 0, 32'h0, 0, 0, 2'b00);
        chk("r026_tmo_drop", 128'(tmo[0]), 128'(1'b0));

        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 2) == 0);
            id = int'($urandom_range(0, NID - 1));
            sz = int'($urandom_range(0, 7));
            ln = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[6:0] = '0;
            clr = '0;
            for (int i = 0; i < NID; i++) clr[i] = ($urandom_range(0, 7) == 0);
            step("rand", v, id, a, sz, ln, clr);
        end

        step("r019_arm", 1'b1, 0, 32'h200, 4, 0, 2'b00);
        chk("r019_armed", 128'(ex_active[0]), 128'(1'b1));
        @(negedge clk);
        set_valid = 1'b0;
        ex_clr    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("r026_async_act", 128'(ex_active), 128'(2'b00));
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("r019_post", 1'b1, 1, 32'h300, 1, 1, 2'b00);
        chk("r019_post_act", 128'(ex_active), 128'(2'b10));
        step("r019_idle", 1'b0, 0, 32'h0, 0, 0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
